sync_fifo_prog: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's 16×8 FIFO. Adds arbitrary (non-power-of-two) depth, run-time programmable almost-full/almost-empty thresholds, an occupancy count, a read-data valid strobe, sticky error flags, and a defined full+read / empty+write concurrency rule. Sits between a producer and a consumer in one clock domain and is driven by the team's existing FIFO bench infrastructure.

---
 rtl/sync_fifo_prog.sv | 123 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty thresholds,
// occupancy count, registered read data with valid strobe, and sticky error flags.
module sync_fifo_prog #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FIFO_WIDTH-1:0] i_data_in,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [CNT_W-1:0]      i_af_thresh,
    input  logic [CNT_W-1:0]      i_ae_thresh,
    input  logic                  i_clr_err,
    output logic [FIFO_WIDTH-1:0] o_data_out,
    output logic                  o_rd_valid,
    output logic                  o_wr_ack,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_ovf_sticky,
    output logic                  o_udf_sticky,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almostfull,
    output logic                  o_almostempty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_ovf_sticky;
    logic                  r_udf_sticky;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ovf;
    logic                  w_udf;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;
    logic [CNT_W-1:0]      w_count_nxt;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_rd_ok = i_rd_en && (r_count != '0);
    assign w_wr_ok = i_wr_en && ((r_count != CNT_FULL) || w_rd_ok);
    assign w_ovf   = i_wr_en && !w_wr_ok;
    assign w_udf   = i_rd_en && !w_rd_ok;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_rd_valid   <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_udf_sticky <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= w_rd_ptr_nxt;
                r_data_out <= r_mem[r_rd_ptr];
            end
            r_count      <= w_count_nxt;
            r_rd_valid   <= w_rd_ok;
            r_wr_ack     <= w_wr_ok;
            r_overflow   <= w_ovf;
            r_underflow  <= w_udf;
            // Set has priority over clear.
            r_ovf_sticky <= w_ovf || (r_ovf_sticky && !i_clr_err);
            r_udf_sticky <= w_udf || (r_udf_sticky && !i_clr_err);
        end
    end

    assign o_data_out    = r_data_out;
    assign o_rd_valid    = r_rd_valid;
    assign o_wr_ack      = r_wr_ack;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
    assign o_ovf_sticky  = r_ovf_sticky;
    assign o_udf_sticky  = r_udf_sticky;
    assign o_count       = r_count;
    assign o_full        = (r_count == CNT_FULL);
    assign o_empty       = (r_count == '0);
    assign o_almostfull  = (r_count >= i_af_thresh);
    assign o_almostempty = (r_count <= i_ae_thresh);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed scenarios plus randomized traffic on a depth-8 instance
// against a queue-based model, and a pointer-wrap scenario on a depth-5 instance.
module tb_sync_fifo_prog;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Depth-8 instance
    logic        rst, wr_en, rd_en, clr_err;
    logic [15:0] data_in;
    logic [3:0]  af_th, ae_th;
    logic [15:0] data_out;
    logic        rd_valid, wr_ack, overflow, underflow, ovf_sticky, udf_sticky;
    logic        full, empty, almostfull, almostempty;
    logic [3:0]  count;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_wr_en(wr_en), .i_rd_en(rd_en),
        .i_af_thresh(af_th), .i_ae_thresh(ae_th), .i_clr_err(clr_err),
        .o_data_out(data_out), .o_rd_valid(rd_valid), .o_wr_ack(wr_ack),
        .o_overflow(overflow), .o_underflow(underflow), .o_ovf_sticky(ovf_sticky),
        .o_udf_sticky(udf_sticky), .o_full(full), .o_empty(empty),
        .o_almostfull(almostfull), .o_almostempty(almostempty), .o_count(count)
    );

    // Depth-5 instance
    logic        rst5, wr5, rd5;
    logic [15:0] din5;
    logic [2:0]  af5, ae5;
    logic [15:0] dout5;
    logic        rv5, ack5, ovf5, udf5, os5, us5, full5, empty5, afl5, ael5;
    logic [2:0]  count5;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (
        .i_clk(clk), .i_rst(rst5), .i_data_in(din5), .i_wr_en(wr5), .i_rd_en(rd5),
        .i_af_thresh(af5), .i_ae_thresh(ae5), .i_clr_err(1'b0),
        .o_data_out(dout5), .o_rd_valid(rv5), .o_wr_ack(ack5),
        .o_overflow(ovf5), .o_underflow(udf5), .o_ovf_sticky(os5),
        .o_udf_sticky(us5), .o_full(full5), .o_empty(empty5),
        .o_almostfull(afl5), .o_almostempty(ael5), .o_count(count5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a queue of stored words plus the registered side outputs.
    logic [15:0] q[$];
    logic [15:0] m_dout;
    logic        m_rv, m_ack, m_ovf, m_udf, m_os, m_us;

    task automatic model_step(input logic r, input logic w, input logic rd,
                              input logic [15:0] d, input logic clr);
        bit rd_ok, wr_ok;
        if (r) begin
            q.delete();
            m_dout = '0;
            {m_rv, m_ack, m_ovf, m_udf, m_os, m_us} = '0;
        end else begin
            rd_ok = rd && (q.size() != 0);
            wr_ok = w && ((q.size() != 8) || rd_ok);
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_rv  = rd_ok;
            m_ack = wr_ok;
            m_ovf = w && !wr_ok;
            m_udf = rd && !rd_ok;
            m_os  = m_ovf || (m_os && !clr);
            m_us  = m_udf || (m_us && !clr);
        end
    endtask

    task automatic check_flags(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".af"}, 32'(almostfull), 32'(n >= int'(af_th)));
        chk({tag, ".ae"}, 32'(almostempty), 32'(n <= int'(ae_th)));
    endtask

    task automatic check_all(input string tag);
        check_flags(tag);
        chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        chk({tag, ".rv"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, ".ack"}, 32'(wr_ack), 32'(m_ack));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, ".os"}, 32'(ovf_sticky), 32'(m_os));
        chk({tag, ".us"}, 32'(udf_sticky), 32'(m_us));
    endtask

    // Drive one cycle's requests, take the edge, then compare against the model.
    task automatic cycle(input string tag, input logic r, input logic w, input logic rd,
                         input logic [15:0] d, input logic clr);
        rst = r; wr_en = w; rd_en = rd; data_in = d; clr_err = clr;
        @(posedge clk);
        #1;
        model_step(r, w, rd, d, clr);
        check_all(tag);
    endtask

    task automatic step5(input logic r, input logic w, input logic rd, input logic [15:0] d);
        rst5 = r; wr5 = w; rd5 = rd; din5 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] q5[$];
        logic [15:0] exp5;
        rst = 1'b1; wr_en = 0; rd_en = 0; data_in = '0; clr_err = 0;
        af_th = 4'd6; ae_th = 4'd2;
        rst5 = 1'b1; wr5 = 0; rd5 = 0; din5 = '0; af5 = 3'd4; ae5 = 3'd1;
        m_os = 0; m_us = 0;
        #1;

        cycle("reset", 1, 0, 0, 16'h0, 0);
        chk("reset.af_consts", 32'(almostfull), 32'd0);

        for (int i = 1; i <= 8; i++) cycle("fill", 0, 1, 0, 16'(i), 0);
        chk("fill.full_at_8", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cycle("drain", 0, 0, 1, 16'h0, 0);
            chk("drain.order", 32'(data_out), 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        for (int i = 1; i <= 8; i++) cycle("refill", 0, 1, 0, 16'(16'h100 + i), 0);
        cycle("ovf", 0, 1, 0, 16'hDEAD, 0);
        chk("ovf.pulse", 32'(overflow), 32'd1);
        cycle("ovf_idle", 0, 0, 0, 16'h0, 0);
        chk("ovf.sticky_holds", 32'(ovf_sticky), 32'd1);
        cycle("clr", 0, 0, 0, 16'h0, 1);
        chk("clr.sticky", 32'(ovf_sticky), 32'd0);

        cycle("full_wr_rd", 0, 1, 1, 16'hAAAA, 0);
        chk("full_wr_rd.count", 32'(count), 32'd8);
        for (int i = 0; i < 7; i++) cycle("drain7", 0, 0, 1, 16'h0, 0);
        cycle("last", 0, 0, 1, 16'h0, 0);
        chk("last.aaaa", 32'(data_out), 32'hAAAA);

        cycle("empty_wr_rd", 0, 1, 1, 16'h1234, 0);
        chk("empty_wr_rd.udf", 32'(underflow), 32'd1);
        chk("empty_wr_rd.cnt", 32'(count), 32'd1);
        cycle("rd1234", 0, 0, 1, 16'h0, 1);
        chk("rd1234.data", 32'(data_out), 32'h1234);

        for (int i = 0; i < 4; i++) cycle("to4", 0, 1, 0, 16'(16'h40 + i), 0);
        cycle("rst_wr", 1, 1, 0, 16'hBEEF, 0);
        chk("rst_wr.count", 32'(count), 32'd0);
        cycle("post_rst", 0, 0, 0, 16'h0, 0);

        // Threshold edge cases take effect combinationally.
        af_th = 4'd0; ae_th = 4'd0; #1;
        check_flags("th_zero");
        af_th = 4'd9; ae_th = 4'd15; #1;
        check_flags("th_big");

        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 150; c++) begin
                int wp;
                wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
                if ((c % 20) == 0) begin
                    af_th = 4'($urandom_range(0, 15));
                    ae_th = 4'($urandom_range(0, 15));
                    #1;
                    check_flags("rnd_th");
                end
                cycle("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < wp),
                      ($urandom_range(0, 99) < (100 - wp)), 16'($urandom), ($urandom_range(0, 9) == 0));
            end
        end

        // Depth-5 wrap: prefill 3, then steady simultaneous traffic.
        step5(1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step5(0, 1, 0, 16'(16'h500 + i));
            q5.push_back(16'(16'h500 + i));
        end
        chk("d5.prefill", 32'(count5), 32'd3);
        for (int i = 0; i < 12; i++) begin
            step5(0, 1, 1, 16'(16'h600 + i));
            q5.push_back(16'(16'h600 + i));
            exp5 = q5.pop_front();
            chk("d5.rv", 32'(rv5), 32'd1);
            chk("d5.data", 32'(dout5), 32'(exp5));
            chk("d5.count", 32'(count5), 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step5(0, 0, 1, 16'h0);
            exp5 = q5.pop_front();
            chk("d5.tail", 32'(dout5), 32'(exp5));
        end
        chk("d5.empty", 32'(empty5), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
